// File: rtl/mux8to1_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux8to1_rr_pkg
// Description : Shared constants and state encoding for the 8-channel
//               mux/demux family (channel count, select width, slot states).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mux8to1_rr_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  // Output slot occupancy: EMPTY means no undelivered word is held.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage : mux8to1_rr_pkg
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick8
// Description : Combinational rotating-priority picker over 8 requests.
//               Scans req starting at index ptr, wrapping modulo 8, and
//               returns the first set request.
// Ports       : req        - in  [7:0] request vector
//               ptr        - in  [2:0] index with highest priority
//               gnt_onehot - out [7:0] one-hot grant (zero when no request)
//               gnt_idx    - out [2:0] index of granted request
//               any        - out       at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
  import mux8to1_rr_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = '0;
    for (int k = 0; k < N_CH; k++) begin
      // 3-bit addition wraps naturally, giving ptr, ptr+1, ... mod 8
      idx = ptr + SEL_W'(k);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule : rr_pick8
`default_nettype wire

// File: rtl/mux8to1_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux8to1_rr
// Description : 8-to-1 round-robin multiplexer with a single registered
//               output slot and valid/ready handshakes on both sides.
// Ports       : clk     - in           clock, rising edge
//               rst     - in           synchronous active-high reset
//               EN      - in           grant enable
//               D       - in  [8*W-1:0] channel data, channel i at [i*W +: W]
//               D_valid - in  [7:0]    per-channel word present
//               D_ready - out [7:0]    combinational one-hot accept strobe
//               Y       - out [W-1:0]  registered selected word
//               sel     - out [2:0]    registered source channel of Y
//               Y_valid - out          Y/sel hold an undelivered word
//               Y_ready - in           downstream accepts Y this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mux8to1_rr
  import mux8to1_rr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic [N_CH*W-1:0] D,
  input  logic [N_CH-1:0]   D_valid,
  output logic [N_CH-1:0]   D_ready,
  output logic [W-1:0]      Y,
  output logic [SEL_W-1:0]  sel,
  output logic              Y_valid,
  input  logic              Y_ready
);

  state_t           state;
  logic [SEL_W-1:0] ptr;

  logic [N_CH-1:0]  gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             any;
  logic             take;
  logic             slot_free;
  logic             grant;

  rr_pick8 u_pick (
    .req        (D_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign Y_valid   = (state == ST_FULL);
  assign take      = Y_valid && Y_ready;
  // The slot can accept in the same cycle it is being emptied, which is
  // what sustains one word per cycle.
  assign slot_free = !Y_valid || Y_ready;
  // rst gates the strobe so no upstream word is consumed while the
  // register is being cleared.
  assign grant     = EN && slot_free && any && !rst;
  assign D_ready   = grant ? gnt_onehot : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      Y     <= '0;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      if (grant) begin
        Y   <= D[gnt_idx*W +: W];
        sel <= gnt_idx;
        ptr <= gnt_idx + SEL_W'(1);
      end
      case (state)
        ST_EMPTY: if (grant)          state <= ST_FULL;
        ST_FULL:  if (take && !grant) state <= ST_EMPTY;
        default:                      state <= ST_EMPTY;
      endcase
    end
  end

endmodule : mux8to1_rr
`default_nettype wire

// File: tb/tb_mux8to1_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux8to1_rr
// Description : Self-checking bench for mux8to1_rr with a reference
//               round-robin model and an output scoreboard.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8to1_rr;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          EN;
  logic [8*W-1:0] D;
  logic [7:0]    D_valid;
  logic [7:0]    D_ready;
  logic [W-1:0]  Y;
  logic [2:0]    sel;
  logic          Y_valid;
  logic          Y_ready;

  mux8to1_rr #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .EN      (EN),
    .D       (D),
    .D_valid (D_valid),
    .D_ready (D_ready),
    .Y       (Y),
    .sel     (sel),
    .Y_valid (Y_valid),
    .Y_ready (Y_ready)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // reference model state
  logic         m_full;
  logic [2:0]   m_ptr;
  logic [W-1:0] m_y;
  logic [2:0]   m_sel;
  logic [10:0]  sb[$];
  logic [7:0]   last_ready;
  int           last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] v, input logic [2:0] p);
    int r;
    logic [2:0] i;
    r = -1;
    for (int k = 0; k < 8; k++) begin
      i = p + 3'(k);
      if (r < 0 && v[i]) r = int'(i);
    end
    return r;
  endfunction

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < 8; i++) D[i*W +: W] = base + 8'(i);
  endtask

  // One clock: check combinational/registered outputs at negedge against
  // the model, advance the model, then move inputs 1 time unit past posedge.
  task automatic step();
    logic [7:0]  er;
    logic [10:0] ent;
    int          g;
    logic        free;
    @(negedge clk);
    free = !m_full || Y_ready;
    g    = pick(D_valid, m_ptr);
    er   = (EN && free && !rst && D_valid != 8'h00) ? (8'h01 << g) : 8'h00;
    chk("d_ready", {24'h0, D_ready}, {24'h0, er});
    chk("y_valid", {31'h0, Y_valid}, {31'h0, m_full});
    chk("y",       {24'h0, Y},       {24'h0, m_y});
    chk("sel",     {29'h0, sel},     {29'h0, m_sel});
    last_ready = D_ready;
    last_g     = (er != 8'h00) ? g : -1;
    if (m_full && Y_ready) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        ent = sb.pop_front();
        chk("sb_word", {21'h0, sel, Y}, {21'h0, ent});
      end
    end
    if (rst) begin
      m_full = 1'b0; m_ptr = 3'd0; m_y = '0; m_sel = 3'd0;
      sb.delete();
    end else if (er != 8'h00) begin
      m_y    = D[g*W +: W];
      m_sel  = 3'(g);
      m_full = 1'b1;
      m_ptr  = 3'(g) + 3'd1;
      sb.push_back({m_sel, m_y});
    end else if (m_full && Y_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; EN = 1'b1; D_valid = 8'hFF; Y_ready = 1'b1; D = '0;
    set_data(8'h10);
    m_full = 1'b0; m_ptr = 3'd0; m_y = '0; m_sel = 3'd0;
    last_ready = 8'h00; last_g = -1;
    @(posedge clk); #1;

    // reset: second reset cycle checked, then first grant favours channel 0
    step();
    rst = 1'b0;
    step();
    chk("first_grant", {24'h0, last_ready}, 32'h01);

    // round robin with no bubbles: grants 1..7,0 follow the first grant
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("rr_grant", last_g, (i % 8));
    end

    // wrap and skip: grant 6 (ptr becomes 7), then 0,2,0
    D_valid = 8'h40; step();
    chk("grant6", last_g, 6);
    D_valid = 8'b0000_0101;
    step(); chk("wrap0", last_g, 0);
    step(); chk("skip2", last_g, 2);
    step(); chk("wrap0b", last_g, 0);
    D_valid = 8'h00; step();

    // backpressure on a held 8'hA5 word
    D[3*W +: W] = 8'hA5;
    D_valid = 8'h08; step();
    chk("bp_grant3", last_g, 3);
    D_valid = 8'hFF; Y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_y", {24'h0, Y}, 32'hA5);
    end
    Y_ready = 1'b1; step();
    chk("bp_release_grant", last_g, 4);
    D_valid = 8'h00; step(); step();

    // EN gating: held word drains while EN=0, then grant to channel 7
    set_data(8'h30);
    D_valid = 8'h01; Y_ready = 1'b0; step();
    EN = 1'b0; D_valid = 8'h80; Y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("en_no_ready", {24'h0, last_ready}, 32'h00);
    end
    EN = 1'b1; step();
    chk("en_grant7", {24'h0, last_ready}, 32'h80);
    D_valid = 8'h00; step();

    // reset mid-transfer drops the held word; next 8'h0C picks channel 2
    D_valid = 8'h20; Y_ready = 1'b0; step();
    rst = 1'b1; D_valid = 8'hFF; step();
    rst = 1'b0; D_valid = 8'h00; step();
    D_valid = 8'h0C; Y_ready = 1'b1; step();
    chk("post_rst_grant2", {24'h0, last_ready}, 32'h04);
    D_valid = 8'h00; step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mux8to1_rr
`default_nettype wire
